// File: rtl/data_memory_responder_if.sv
// Purpose: load/store port between the CPU (master) and the data-memory responder (slave).
// Latency: none, this only bundles wires.
// Backpressure: busy_o from the slave stalls the master while a request is in flight.
interface data_memory_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  busy_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output busy_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// Purpose: multi-cycle word memory serving one CPU load/store at a time, with error flagging.
// Latency: ack_o pulses LATENCY edges after the accepting edge; a new request can be accepted in the ack cycle.
// Backpressure: busy_o stays high while waiting, and req_i is ignored until the ack cycle.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    data_memory_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;

    // Storage is deliberately left unreset; contents are undefined until written.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          bad;
    logic [AW-1:0] idx;
    logic          mem_we;
    logic [31:0]   rdata_d;

    // Decode the latched request: error check, word index and the access result.
    always_comb begin
        accept  = ((state_q == S_IDLE) || (state_q == S_ACK)) && bus.req_i;
        access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
        bad     = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
        idx     = addr_q[AW+1:2];
        mem_we  = access && we_q && !bad;
        rdata_d = (we_q || bad) ? 32'd0 : mem_q[idx];
    end

    // Word write at the completion edge; reset gates it so an abandoned store never lands.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Request FSM with registered busy/ack/err/rdata outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACK: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (accept) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (access) begin
                        rdata_q <= rdata_d;
                        ack_q   <= 1'b1;
                        err_q   <= bad;
                        busy_q  <= 1'b0;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Purpose: exercises two responders (latency 4 and latency 1) against a word-array reference model.
// Latency: each request is expected to ack exactly LATENCY edges after acceptance.
// Backpressure: requests are driven only when the responder can accept, except deliberate ignored pulses.
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    data_memory_responder_if bus4 ();
    data_memory_responder_if bus1 ();

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4.slave)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    // Reference memories: only words the bench has written are ever loaded.
    logic [31:0] m4 [int];
    logic [31:0] m1 [int];

    task automatic drive(input int w, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (w != 0) begin
            bus1.req_i = req; bus1.we_i = we; bus1.addr_i = a; bus1.wdata_i = d;
        end else begin
            bus4.req_i = req; bus4.we_i = we; bus4.addr_i = a; bus4.wdata_i = d;
        end
    endtask

    function automatic logic g_ack(input int w);
        return (w != 0) ? bus1.ack_o : bus4.ack_o;
    endfunction
    function automatic logic g_busy(input int w);
        return (w != 0) ? bus1.busy_o : bus4.busy_o;
    endfunction
    function automatic logic g_err(input int w);
        return (w != 0) ? bus1.err_o : bus4.err_o;
    endfunction
    function automatic logic [31:0] g_rd(input int w);
        return (w != 0) ? bus1.rdata_o : bus4.rdata_o;
    endfunction

    // One full request from an idle responder, checked for timing, data and error.
    // Called at a negedge; returns at a negedge with the responder idle.
    task automatic run_req(input int w, input bit we, input logic [31:0] a, input logic [31:0] d, input string nm);
        int          n, nb, lat;
        bit          got;
        bit          e_err;
        logic [31:0] e_rd;
        int          ix;
        lat   = (w != 0) ? 1 : 4;
        e_err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
        ix    = int'(a >> 2);
        e_rd  = 32'd0;
        if (!e_err && !we) e_rd = (w != 0) ? m1[ix] : m4[ix];
        if (!e_err && we) begin
            if (w != 0) m1[ix] = d; else m4[ix] = d;
        end
        drive(w, 1'b1, we, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
        n = 0; nb = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (g_ack(w)) got = 1;
            else begin
                if (g_busy(w)) nb++;
                @(posedge clk); n++;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL %s timeout: no ack within 40 cycles", nm); end
        n_cmp++;
        if (n !== lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat); end
        n_cmp++;
        if (nb !== lat) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, nb, lat); end
        n_cmp++;
        if (g_busy(w) !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_ack: got %b want 0", nm, g_busy(w)); end
        n_cmp++;
        if (g_rd(w) !== e_rd) begin n_bad++; $display("FAIL %s rdata: got %h want %h", nm, g_rd(w), e_rd); end
        n_cmp++;
        if (g_err(w) !== e_err) begin n_bad++; $display("FAIL %s err: got %b want %b", nm, g_err(w), e_err); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({g_ack(w), g_err(w), g_busy(w)} !== 3'b000) begin
            n_bad++; $display("FAIL %s after_ack: ack/err/busy got %b want 000", nm, {g_ack(w), g_err(w), g_busy(w)});
        end
        n_cmp++;
        if (g_rd(w) !== e_rd) begin n_bad++; $display("FAIL %s rdata_hold: got %h want %h", nm, g_rd(w), e_rd); end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus4.busy_o, bus4.ack_o, bus4.err_o, bus4.rdata_o} !== 35'd0) begin
            n_bad++; $display("FAIL reset_outputs: got busy=%b ack=%b err=%b rdata=%h want all 0",
                              bus4.busy_o, bus4.ack_o, bus4.err_o, bus4.rdata_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus4.busy_o, bus4.ack_o, bus1.busy_o, bus1.ack_o} !== 4'b0000) begin
                n_bad++; $display("FAIL idle_cycle%0d: busy/ack got %b want 0000", i,
                                  {bus4.busy_o, bus4.ack_o, bus1.busy_o, bus1.ack_o});
            end
        end
    endtask

    task automatic test_store_load();
        run_req(0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
        run_req(0, 1'b0, 32'h10, 32'h0, "load_10");
    endtask

    task automatic test_back_to_back();
        int          k, t0, cyc;
        int          t_ack [3];
        logic [31:0] r_ack [3];
        run_req(0, 1'b1, 32'h0, 32'd1, "pre0");
        run_req(0, 1'b1, 32'h4, 32'd2, "pre4");
        run_req(0, 1'b1, 32'h8, 32'd3, "pre8");
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus4.addr_i = 32'h4;
        k = 0; cyc = 0; t0 = 0;
        while (k < 3 && cyc < 60) begin
            if (bus4.ack_o) begin
                t_ack[k] = cyc; r_ack[k] = bus4.rdata_o; k++;
                @(posedge clk); cyc++;
                @(negedge clk);
                if (k == 1) bus4.addr_i = 32'h8;
                if (k == 2) bus4.req_i = 1'b0;
            end else begin
                @(posedge clk); cyc++;
                @(negedge clk);
            end
        end
        bus4.req_i = 1'b0;
        n_cmp++;
        if (k !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d acks want 3", k); end
        for (int i = 0; i < 3; i++) begin
            if (i < k) begin
                n_cmp++;
                if (r_ack[i] !== 32'(i + 1)) begin
                    n_bad++; $display("FAIL b2b_rdata%0d: got %h want %h", i, r_ack[i], 32'(i + 1));
                end
                if (i > 0) begin
                    n_cmp++;
                    if (t_ack[i] - t_ack[i-1] !== 5) begin
                        n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 5", i, t_ack[i] - t_ack[i-1]);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_errors();
        run_req(0, 1'b1, 32'h13, 32'hCAFE0013, "store_misaligned");
        run_req(0, 1'b0, 32'h10, 32'h0, "load_10_unchanged");
        run_req(0, 1'b0, 32'h400, 32'h0, "load_out_of_range");
        run_req(0, 1'b1, 32'h8000_0020, 32'h1234, "store_high_addr");
        run_req(0, 1'b0, 32'h20 + 32'h0, 32'h0, "probe_20_preset") ;
    endtask

    task automatic test_reset_wait();
        drive(0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus4.busy_o, bus4.ack_o, bus4.err_o, bus4.rdata_o} !== 35'd0) begin
            n_bad++; $display("FAIL reset_async: busy=%b ack=%b err=%b rdata=%h want all 0",
                              bus4.busy_o, bus4.ack_o, bus4.err_o, bus4.rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus4.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_no_ack%0d: got %b want 0", i, bus4.ack_o); end
        end
        run_req(0, 1'b0, 32'h20, 32'h0, "load_20_after_reset");
    endtask

    task automatic test_ignored_req();
        int acks;
        logic [31:0] rd;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hBAD0BAD0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0, 32'hBAD0BAD0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        acks = 0; rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            if (bus4.ack_o) begin acks++; rd = bus4.rdata_o; end
            @(negedge clk);
        end
        n_cmp++;
        if (acks !== 1) begin n_bad++; $display("FAIL ignored_req_acks: got %0d want 1", acks); end
        n_cmp++;
        if (rd !== m4[4]) begin n_bad++; $display("FAIL ignored_req_rdata: got %h want %h", rd, m4[4]); end
        run_req(0, 1'b0, 32'h0, 32'h0, "load_0_not_clobbered");
        run_req(1, 1'b1, 32'h30, 32'hA5A5_0001, "lat1_store");
        run_req(1, 1'b0, 32'h30, 32'h0, "lat1_load");
        run_req(1, 1'b0, 32'h31, 32'h0, "lat1_misaligned");
    endtask

    task automatic test_random();
        int          w, kind, ix;
        bit          we;
        logic [31:0] a;
        string       nm;
        for (int i = 0; i < 40; i++) begin
            w    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            we   = 1'($urandom_range(0, 1));
            if (kind == 0) a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
            else if (kind == 1) a = $urandom_range(256, 32'h2000_0000) << 2;
            else begin
                ix = int'($urandom_range(0, 15));
                a  = 32'(ix) << 2;
                if (w != 0 && !m1.exists(ix)) we = 1'b1;
                if (w == 0 && !m4.exists(ix)) we = 1'b1;
            end
            nm = $sformatf("rand%0d", i);
            run_req(w, we, a, $urandom, nm);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        m4[8] = 32'h0000_0777;
        run_req(0, 1'b1, 32'h20, 32'h0000_0777, "store_20_prior");
        test_errors();
        test_reset_wait();
        test_ignored_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store port. It accepts one load or store request at a time, holds the CPU off with a stall signal for a fixed, parameterised latency, performs the word access, and returns a one-cycle acknowledge with read data or an error flag. It replaces the zero-latency data memory when the core is run against realistic memory timing.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- LATENCY, 4: edges from request acceptance to ack; range 1..15.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  request strobe; sampled only when the block can accept.
- we_i  input  1  1 = store, 0 = load; sampled with req_i.
- addr_i  input  32  byte address; word index = addr_i[31:2].
- wdata_i  input  32  store data; sampled with req_i.
- busy_o  output  1  stall to the CPU: request in flight, not yet acknowledged.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load result; valid while ack_o = 1, held afterwards.
- err_o  output  1  qualifies ack_o: request was misaligned or out of range.

## Operation
- Three-state FSM:
  - IDLE: no request in flight.
  - WAIT: down-counter running.
  - ACK: response presented.
- Accept: req_i = 1 at a rising edge while in IDLE or ACK.
  - Latch we, addr and wdata.
  - Load counter with LATENCY-1.
  - Go to WAIT.
- WAIT, counter ≠ 0: decrement; req_i is ignored.
- WAIT, counter = 0: perform the access at that edge and go to ACK.
  - Load: rdata_o ← mem[word index].
  - Store: mem[word index] ← wdata; rdata_o ← 0.
- ACK: ack_o = 1.
  - req_i = 1 starts a new request (back-to-back).
  - Otherwise go to IDLE.
- Error: addr[1:0] ≠ 0 or addr[31:2] ≥ DEPTH_WORDS.
  - Request is still accepted and timed normally.
  - No memory write; rdata_o ← 0; err_o = 1 during ACK.
- busy_o = 1 exactly in WAIT.
- ack_o and err_o are 0 outside ACK.
- Memory array is not reset; contents are undefined until written.
- A read of a word written by the immediately preceding request returns the new data.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - busy_o = 0, ack_o = 0, err_o = 0, rdata_o = 0.
- Reset asserted mid-request: the request is abandoned.
  - A pending store is NOT performed.
  - No ack is produced after reset releases.
- Latency: acceptance at edge E.
  - busy_o high after E.
  - Access performed and ack_o high after edge E+LATENCY, for exactly one cycle.
  - busy_o low in the same cycle ack_o rises.
- Throughput: one request per LATENCY+1 cycles with back-to-back requests (accept in the ACK cycle).
- LATENCY = 1: WAIT lasts one cycle; ack after E+1.
- rdata_o holds its value through IDLE until the next ack.
- Inputs other than req_i are don't-care except at the acceptance edge.
- Changes to inputs during WAIT have no effect.
- Simultaneous req_i and ack: the new request is accepted; the current ack still lasts exactly one cycle.

## Test plan
- Reset then idle: assert rst_i asynchronously mid-cycle.
  - Outputs go to 0 immediately.
  - req_i = 0 for 10 cycles → busy_o = 0 and ack_o = 0 throughout.
- Store then load, LATENCY = 4: store 0xDEADBEEF to 0x10, then load 0x10.
  - Store: busy_o high 4 cycles, ack_o 1 cycle, rdata_o = 0.
  - Load: ack after 4 edges, rdata_o = 0xDEADBEEF, err_o = 0.
- Back-to-back: req_i held high for 3 loads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3).
  - Acks 5 cycles apart; rdata_o sequence 1, 2, 3.
- Errors, each acked with err_o = 1 and rdata_o = 0:
  - Store to 0x13 (misaligned) → the word at 0x10 stays unchanged.
  - Load from 0x400 with DEPTH_WORDS = 256 → out of range.
- Reset during WAIT: store 0x55 to 0x20, assert rst_i after 2 cycles, release.
  - No ack appears.
  - Subsequent load of 0x20 returns the prior value, not 0x55.
- Ignored request and LATENCY = 1:
  - req_i pulsed during WAIT is not accepted and produces no extra ack.
  - With LATENCY = 1, ack follows acceptance by exactly 1 edge.
